gauss_window_feeder: RTL and testbench
======================================

Name: gauss_window_feeder

Overview:
- Producer side of the 3x3 Gaussian filter's window interface.
- Accepts a raster pixel stream with a valid/ready handshake and buffers two image lines.
- Builds the 3x3 neighbourhood for every interior pixel, presents the nine pixels to the filter, and holds its enable high until the filter's done pulse.
- Captures the filtered result and forwards it as a one-cycle valid output; signals end of frame.

Parameters:
- IMG_W, 128, image width in pixels (>=3)
- IMG_H, 128, image height in lines (>=3)
- TIMEOUT, 255, max cycles en_o may stay high without done_i before err_o sets

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- px_i  in  8  input pixel, raster order
- px_valid_i  in  1  px_i valid
- px_ready_o  out  1  feeder accepts px_i this cycle
- win_0_o..win_8_o  out  8 each  window pixels, row-major: win_0 = top-left (x-2,y-2), win_8 = newest (x,y)
- en_o  out  1  filter enable; held high while a window is pending
- done_i  in  1  filter result-ready pulse
- res_i  in  8  filter result, sampled when done_i=1
- res_o  out  8  forwarded result
- res_valid_o  out  1  one-cycle pulse with res_o
- frame_done_o  out  1  one-cycle pulse after the last window's result
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_i=1) clears all of the following:
  - state=FILL, x=y=0
  - px_ready_o=1, en_o=0, res_valid_o=0, frame_done_o=0, err_o=0
  - window regs=0, res_o=0
- Line buffers lb0 (row y-1) and lb1 (row y-2), IMG_W x 8 each, are not cleared. Their stale data is never issued because windows are gated on y>=2.
- Handshake: a pixel is accepted when px_valid_i && px_ready_o. px_ready_o=1 only in FILL.
- On accept at column x:
  - New column = {lb1[x], lb0[x], px_i}.
  - Window shifts one column left and the new column enters the right.
  - lb1[x]<=lb0[x]; lb0[x]<=px_i.
  - x increments. At x=IMG_W-1, x wraps to 0 and y increments. At y=IMG_H-1 with x=IMG_W-1, y wraps to 0.
- Window valid on accept iff x>=2 && y>=2, using pre-increment coordinates.
- States:
  - FILL: accept pixels. An accept that completes a valid window goes to ISSUE in the next cycle.
  - ISSUE:
    - en_o=1; window outputs frozen; timeout counter counts up.
    - On done_i=1: res_o<=res_i, res_valid_o=1 for one cycle, go to GAP. If the issued window was the frame's last (x=IMG_W-1, y=IMG_H-1), also pulse frame_done_o in that same cycle.
    - If the counter reaches TIMEOUT before done_i: err_o<=1 (sticky until reset), en_o drops, go to GAP with no res_valid_o.
  - GAP:
    - en_o=0 for exactly one cycle, which lets the filter return to its idle state.
    - px_ready_o=0.
    - Next state FILL.
- Latency:
  - Completing accept in cycle N gives en_o=1 from cycle N+1.
  - done_i in cycle M gives res_valid_o in cycle M+1, then FILL at M+2.
- done_i seen in FILL or GAP is ignored (no res_valid_o, no state change).
- Non-window pixels (border rows/columns) are accepted back-to-back at one per cycle.
- Output image size: (IMG_W-2) x (IMG_H-2) results per frame.
- Reset mid-ISSUE: en_o drops asynchronously. The pending window is discarded. The next frame starts at x=y=0.

Test Plan:
- IMG_W=IMG_H=4, ramp px=4y+x, behavioural filter model:
  - First en_o follows accept of px=10 with window 0,1,2/4,5,6/8,9,10.
  - Result 80>>4=5 on res_o with a one-cycle res_valid_o.
  - Exactly 4 res_valid_o per frame; frame_done_o coincides with the 4th.
- Constant image 100, 4x4 -> four results, each 100; window outputs all 100 while en_o=1.
- Backpressure: px_valid_i held high through ISSUE -> px_ready_o=0 throughout; no pixel lost or duplicated; GAP shows en_o=0 for exactly one cycle.
- Timeout: TIMEOUT=16, done_i tied 0 -> err_o=1 sixteen cycles after en_o rises; en_o drops; no res_valid_o; err_o stays 1 until reset.
- Stray done_i pulse in FILL -> no res_valid_o, no state change.
- Reset mid-ISSUE, then a fresh ramp frame -> en_o=0 immediately; the first window again matches 0,1,2/4,5,6/8,9,10.

Source files
------------

// File: rtl/gauss_window_feeder.sv
// Producer side of the 3x3 Gaussian filter window interface: buffers two raster lines,
// issues every interior 3x3 neighbourhood to the filter and forwards the filtered result.
module gauss_window_feeder #(
  parameter int IMG_W   = 128,
  parameter int IMG_H   = 128,
  parameter int TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] px_i,
  input  logic       px_valid_i,
  output logic       px_ready_o,
  output logic [7:0] win_0_o,
  output logic [7:0] win_1_o,
  output logic [7:0] win_2_o,
  output logic [7:0] win_3_o,
  output logic [7:0] win_4_o,
  output logic [7:0] win_5_o,
  output logic [7:0] win_6_o,
  output logic [7:0] win_7_o,
  output logic [7:0] win_8_o,
  output logic       en_o,
  input  logic       done_i,
  input  logic [7:0] res_i,
  output logic [7:0] res_o,
  output logic       res_valid_o,
  output logic       frame_done_o,
  output logic       err_o,
  output logic [1:0] dbg_state_o
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [TW-1:0] tmo_cnt;
  logic          last_win;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    win [9];

  logic accept;
  logic x_last;
  logic y_last;
  logic win_ok;

  // Handshake: px_i is consumed on any cycle with px_valid_i && px_ready_o; px_ready_o is
  // high only in FILL, so the producer holds px_i/px_valid_i stable until it is taken.
  assign accept = px_valid_i && px_ready_o;
  assign x_last = (x == XW'(IMG_W - 1));
  assign y_last = (y == YW'(IMG_H - 1));
  assign win_ok = (x >= XW'(2)) && (y >= YW'(2));

  assign win_0_o     = win[0];
  assign win_1_o     = win[1];
  assign win_2_o     = win[2];
  assign win_3_o     = win[3];
  assign win_4_o     = win[4];
  assign win_5_o     = win[5];
  assign win_6_o     = win[6];
  assign win_7_o     = win[7];
  assign win_8_o     = win[8];
  assign dbg_state_o = state;

  // Line buffers hold no reset: stale contents only reach rows y<2, which never issue.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[x] <= lb0[x];
      lb0[x] <= px_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= FILL;
      x            <= '0;
      y            <= '0;
      tmo_cnt      <= '0;
      last_win     <= 1'b0;
      px_ready_o   <= 1'b1;
      en_o         <= 1'b0;
      res_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
      res_o        <= '0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      res_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            // Shift the window left; the new column is {row y-2, row y-1, row y}.
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb1[x];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb0[x];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= px_i;
            if (x_last) begin
              x <= '0;
              y <= y_last ? '0 : y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
            if (win_ok) begin
              state      <= ISSUE;
              en_o       <= 1'b1;
              px_ready_o <= 1'b0;
              tmo_cnt    <= '0;
              last_win   <= x_last && y_last;
            end
          end
        end
        ISSUE: begin
          if (done_i) begin
            res_o        <= res_i;
            res_valid_o  <= 1'b1;
            frame_done_o <= last_win;
            en_o         <= 1'b0;
            state        <= GAP;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            err_o <= 1'b1;
            en_o  <= 1'b0;
            state <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        GAP: begin
          // One idle cycle with en_o low lets the filter fall back to idle.
          state      <= FILL;
          px_ready_o <= 1'b1;
        end
        default: begin
          state      <= FILL;
          en_o       <= 1'b0;
          px_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gauss_window_feeder.sv
// Bench for gauss_window_feeder on a 4x4 image with a behavioural 3x3 Gaussian filter model
// and a scoreboard of expected {frame_done, result} pairs.
`timescale 1ns/1ps
module tb_gauss_window_feeder;

  localparam int W        = 4;
  localparam int H        = 4;
  localparam int TMO      = 16;
  localparam int FILT_LAT = 2;
  localparam int NPX      = W * H;

  logic       clk;
  logic       rst_i;
  logic [7:0] px_i;
  logic       px_valid_i;
  logic       px_ready_o;
  logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic       en_o;
  logic       done_i;
  logic [7:0] res_i;
  logic [7:0] res_o;
  logic       res_valid_o;
  logic       frame_done_o;
  logic       err_o;
  logic [1:0] dbg_state_o;

  logic       filt_done;
  logic       stray_done;
  logic [7:0] filt_res;
  bit         filt_on;
  logic [7:0] wv [9];

  int errors = 0;
  int checks = 0;
  int n_res, n_fd, bp_viol, gap_bad, win_bad, lat_bad;
  logic [7:0] first_win [9];
  logic [7:0] first_res;
  logic [7:0] ref_w [9] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
  logic [8:0] exp_q [$];

  assign done_i = filt_done | stray_done;
  assign res_i  = filt_res;

  always_comb begin
    wv[0] = w0; wv[1] = w1; wv[2] = w2;
    wv[3] = w3; wv[4] = w4; wv[5] = w5;
    wv[6] = w6; wv[7] = w7; wv[8] = w8;
  end

  gauss_window_feeder #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .px_i(px_i), .px_valid_i(px_valid_i), .px_ready_o(px_ready_o),
    .win_0_o(w0), .win_1_o(w1), .win_2_o(w2),
    .win_3_o(w3), .win_4_o(w4), .win_5_o(w5),
    .win_6_o(w6), .win_7_o(w7), .win_8_o(w8),
    .en_o(en_o), .done_i(done_i), .res_i(res_i),
    .res_o(res_o), .res_valid_o(res_valid_o), .frame_done_o(frame_done_o),
    .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gauss(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    int s;
    s = a0 + 2*a1 + a2 + 2*a3 + 4*a4 + 2*a5 + a6 + 2*a7 + a8;
    return 8'(s >> 4);
  endfunction

  // Filter model: answers FILT_LAT cycles after en_o rises, then waits for en_o to drop.
  int fst, fcnt;
  initial begin
    filt_done = 1'b0;
    filt_res  = '0;
    fst       = 0;
    fcnt      = 0;
    forever begin
      @(posedge clk); #1;
      if (rst_i || !filt_on) begin
        filt_done = 1'b0;
        fst       = 0;
      end else begin
        case (fst)
          0: if (en_o) begin fcnt = 0; fst = 1; end
          1: begin
            fcnt++;
            if (fcnt == FILT_LAT) begin
              filt_done = 1'b1;
              filt_res  = gauss(wv[0], wv[1], wv[2], wv[3], wv[4], wv[5], wv[6], wv[7], wv[8]);
              fst       = 2;
            end
          end
          default: begin
            filt_done = 1'b0;
            if (!en_o) fst = 0;
          end
        endcase
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    rst_i      = 1'b1;
    px_valid_i = 1'b0;
    stray_done = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_px(input logic [7:0] p, output int ncyc);
    bit got;
    got  = 1'b0;
    ncyc = 0;
    px_i = p;
    px_valid_i = 1'b1;
    while (!got && ncyc < 100) begin
      got = px_ready_o;
      ncyc++;
      @(posedge clk); #1;
    end
    px_valid_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_px: pixel %0d not accepted after %0d cycles", p, ncyc);
    end
  endtask

  // Streams pixels start..NPX-1 with px_valid_i held high; scoreboards every result.
  task automatic run_frame(input int mode, input int start);
    logic [7:0] img [NPX];
    logic [7:0] ew [9];
    logic [8:0] e;
    int   idx, bx, by, tail, cyc;
    bit   prev_en, gap_pend, first, acc, en_exp, done_prev, fin;
    for (int i = 0; i < NPX; i++) img[i] = (mode == 0) ? 8'(i) : 8'd100;
    for (int k = 0; k < 9; k++) ew[k] = '0;
    idx = start; tail = 0; fin = 1'b0;
    prev_en = en_o; gap_pend = 1'b0; first = 1'b1; en_exp = 1'b0; done_prev = 1'b0;
    n_res = 0; n_fd = 0; bp_viol = 0; gap_bad = 0; win_bad = 0; lat_bad = 0;
    first_res = '0;
    for (cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (en_o && px_ready_o) bp_viol++;
      if (gap_pend) begin
        if (!px_ready_o) gap_bad++;
        gap_pend = 1'b0;
      end
      if (prev_en && !en_o) begin
        if (px_ready_o) gap_bad++;
        gap_pend = 1'b1;
      end
      if (en_exp && en_o !== 1'b1) lat_bad++;
      en_exp = 1'b0;
      if (done_prev && res_valid_o !== 1'b1) lat_bad++;
      if (en_o) begin
        for (int k = 0; k < 9; k++) if (wv[k] !== ew[k]) win_bad++;
        if (first && !prev_en) begin
          for (int k = 0; k < 9; k++) first_win[k] = wv[k];
          first = 1'b0;
        end
      end
      if (frame_done_o) n_fd++;
      if (res_valid_o) begin
        if (n_res == 0) first_res = res_o;
        n_res++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: unexpected result %0d fd=%0d", res_o, frame_done_o);
        end else begin
          e = exp_q.pop_front();
          if ({frame_done_o, res_o} !== e)begin
            errors++;
            $display("FAIL scoreboard: got fd=%0d res=%0d exp fd=%0d res=%0d",
                     frame_done_o, res_o, e[8], e[7:0]);
          end
        end
      end
      prev_en = en_o;
      if (idx < NPX) begin
        px_valid_i = 1'b1;
        px_i       = img[idx];
        acc        = px_ready_o;
      end else begin
        px_valid_i = 1'b0;
        acc        = 1'b0;
      end
      @(negedge clk);
      done_prev = done_i;
      @(posedge clk); #1;
      if (acc) begin
        bx = idx % W;
        by = idx / W;
        if (bx >= 2 && by >= 2) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              ew[r*3+c] = img[(by-2+r)*W + (bx-2+c)];
          exp_q.push_back({(bx == W-1 && by == H-1),
                           gauss(ew[0], ew[1], ew[2], ew[3], ew[4], ew[5], ew[6], ew[7], ew[8])});
          en_exp = 1'b1;
        end
        idx++;
      end
      if (idx == NPX && exp_q.size() == 0) begin
        tail++;
        if (tail > 3) fin = 1'b1;
      end
    end
    px_valid_i = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL run_frame_budget: idx=%0d pending=%0d after %0d cycles", idx, exp_q.size(), cyc);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_i = 1'b1;
    px_valid_i = 1'b0;
    stray_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (px_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b exp 1", px_ready_o); end
    checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b exp 0", en_o); end
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b exp 0", res_valid_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b exp 0", frame_done_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", err_o); end
    checks++; if (res_o !== 8'd0) begin errors++; $display("FAIL reset_res: got %0d exp 0", res_o); end
    checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state_o); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (wv[k] !== 8'd0) begin errors++; $display("FAIL reset_win%0d: got %0d exp 0", k, wv[k]); end
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    do_reset();
    filt_on = 1'b1;
    run_frame(0, 0);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (first_win[k] !== ref_w[k]) begin errors++; $display("FAIL ramp_first_win%0d: got %0d exp %0d", k, first_win[k], ref_w[k]); end
    end
    checks++; if (first_res !== 8'd5) begin errors++; $display("FAIL ramp_first_res: got %0d exp 5", first_res); end
    checks++; if (n_res != 4) begin errors++; $display("FAIL ramp_count: got %0d exp 4", n_res); end
    checks++; if (n_fd != 1) begin errors++; $display("FAIL ramp_frame_done: got %0d exp 1", n_fd); end
    checks++; if (win_bad != 0) begin errors++; $display("FAIL ramp_win_stable: got %0d bad exp 0", win_bad); end
    checks++; if (lat_bad != 0) begin errors++; $display("FAIL ramp_latency: got %0d bad exp 0", lat_bad); end
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0);
    checks++; if (n_res != 4) begin errors++; $display("FAIL b2b_count: got %0d exp 4", n_res); end
    checks++; if (n_fd != 1) begin errors++; $display("FAIL b2b_frame_done: got %0d exp 1", n_fd); end
    checks++; if (bp_viol != 0) begin errors++; $display("FAIL b2b_ready_in_issue: got %0d exp 0", bp_viol); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL b2b_gap: got %0d bad exp 0", gap_bad); end
    checks++; if (lat_bad != 0) begin errors++; $display("FAIL b2b_latency: got %0d bad exp 0", lat_bad); end
  endtask

  task automatic test_const();
    do_reset();
    run_frame(1, 0);
    checks++; if (n_res != 4) begin errors++; $display("FAIL const_count: got %0d exp 4", n_res); end
    checks++; if (first_res !== 8'd100) begin errors++; $display("FAIL const_res: got %0d exp 100", first_res); end
    checks++; if (win_bad != 0) begin errors++; $display("FAIL const_win: got %0d bad exp 0", win_bad); end
  endtask

  task automatic test_timeout();
    int n, tot, k;
    bit got, rv;
    do_reset();
    filt_on = 1'b0;
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      send_px(8'(i), n);
      tot += n;
    end
    checks++; if (tot != 10) begin errors++; $display("FAIL border_back_to_back: got %0d cycles exp 10", tot); end
    send_px(8'd10, n);
    checks++; if (en_o !== 1'b1) begin errors++; $display("FAIL tmo_en_rise: got %0b exp 1", en_o); end
    got = 1'b0;
    rv  = 1'b0;
    for (k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (res_valid_o) rv = 1'b1;
      if (err_o) got = 1'b1;
    end
    k--;
    checks++; if (!got || k != TMO) begin errors++; $display("FAIL tmo_delay: got %0d cycles (seen=%0b) exp %0d", k, got, TMO); end
    checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL tmo_en_drop: got %0b exp 0", en_o); end
    repeat (10) begin
      @(posedge clk); #1;
      if (res_valid_o) rv = 1'b1;
    end
    checks++; if (rv) begin errors++; $display("FAIL tmo_no_result: got res_valid exp none"); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %0b exp 1", err_o); end
    checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL tmo_back_to_fill: got %0d exp 0", dbg_state_o); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_reset_clears: got %0b exp 0", err_o); end
  endtask

  task automatic test_stray_done();
    int n;
    do_reset();
    filt_on = 1'b0;
    for (int i = 0; i < 3; i++) send_px(8'(i), n);
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL stray_res_valid: got %0b exp 0", res_valid_o); end
    checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL stray_state: got %0d exp 0", dbg_state_o); end
    checks++; if (px_ready_o !== 1'b1) begin errors++; $display("FAIL stray_ready: got %0b exp 1", px_ready_o); end
    filt_on = 1'b1;
    run_frame(0, 3);
    checks++; if (n_res != 4) begin errors++; $display("FAIL stray_count: got %0d exp 4", n_res); end
    checks++; if (win_bad != 0) begin errors++; $display("FAIL stray_win: got %0d bad exp 0", win_bad); end
  endtask

  task automatic test_reset_mid_issue();
    int n;
    do_reset();
    filt_on = 1'b0;
    for (int i = 0; i <= 10; i++) send_px(8'(i), n);
    repeat (3) @(posedge clk);
    #3;
    checks++; if (en_o !== 1'b1) begin errors++; $display("FAIL mid_issue_en: got %0b exp 1", en_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL mid_reset_en: got %0b exp 0", en_o); end
    checks++; if (px_ready_o !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %0b exp 1", px_ready_o); end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    filt_on = 1'b1;
    run_frame(0, 0);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (first_win[k] !== ref_w[k]) begin errors++; $display("FAIL mid_first_win%0d: got %0d exp %0d", k, first_win[k], ref_w[k]); end
    end
    checks++; if (n_res != 4) begin errors++; $display("FAIL mid_count: got %0d exp 4", n_res); end
  endtask

  initial begin
    rst_i      = 1'b1;
    px_i       = '0;
    px_valid_i = 1'b0;
    stray_done = 1'b0;
    filt_on    = 1'b1;
    test_reset();
    test_ramp();
    test_back_to_back();
    test_const();
    test_timeout();
    test_stray_done();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
